// File: rtl/posit_stft_pkg.sv
// Shared definitions for the posit STFT frame controller.
// Holds the FFT size, the default posit word width, the controller state
// type and a few posit constants used by tests and neighbouring blocks.
// Optional feature macro used by the top: STFT_FRAME_CNT_EN.
package posit_stft_pkg;

    localparam int NPT        = 4;   // FFT points per frame
    localparam int DEFAULT_DW = 32;  // default posit width per component

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,  // collecting samples into the frame buffer
        ST_ISSUE = 2'd1,  // frame presented to the datapath
        ST_HOLD  = 2'd2   // spectrum held until the consumer takes it
    } stft_state_t;

    localparam logic [31:0] POSIT_ONE  = 32'h4000_0000;
    localparam logic [31:0] POSIT_ZERO = 32'h0000_0000;

    // Fill level left in the buffer after sliding the window by hop samples.
    // A hop of a whole frame empties the buffer.
    function automatic logic [1:0] refill_cnt(input int hop);
        int left;
        left = (hop >= NPT) ? 0 : (NPT - hop);
        return 2'(left);
    endfunction

endpackage

// File: rtl/posit_stft_frame_buf.sv
// Four-slot complex sample buffer for the STFT frame controller.
// Slot i occupies bits [i*DW +: DW] of x_re/x_im; slot 0 is the oldest.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears all slots)
//   wr_en, wr_idx    write the sample wr_re/wr_im into slot wr_idx
//   shift_en         slide the window: slot i takes slot i+HOP, the vacated
//                    upper slots are zero-filled (takes priority over writes)
//   x_re, x_im       whole buffer, always visible
module posit_stft_frame_buf
    import posit_stft_pkg::*;
#(
    parameter int DW  = DEFAULT_DW,
    parameter int HOP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [DW-1:0]     wr_re,
    input  logic [DW-1:0]     wr_im,
    input  logic              shift_en,
    output logic [NPT*DW-1:0] x_re,
    output logic [NPT*DW-1:0] x_im
);

    // A right shift of the packed buffer by HOP slots implements
    // x[i] <= x[i+HOP] and zero-fills the slots that fall off the top,
    // keeping the don't-care slots deterministic.
    localparam int SHIFT_BITS = HOP * DW;

    logic [NPT*DW-1:0] slots_re;
    logic [NPT*DW-1:0] slots_im;
    logic [NPT-1:0]    wr_sel;

    for (genvar gi = 0; gi < NPT; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (wr_idx == 2'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_re <= '0;
            slots_im <= '0;
        end else if (shift_en) begin
            slots_re <= slots_re >> SHIFT_BITS;
            slots_im <= slots_im >> SHIFT_BITS;
        end else begin
            for (int i = 0; i < NPT; i++) begin
                if (wr_sel[i]) begin
                    slots_re[i*DW +: DW] <= wr_re;
                    slots_im[i*DW +: DW] <= wr_im;
                end
            end
        end
    end

    assign x_re = slots_re;
    assign x_im = slots_im;

endmodule

// File: rtl/posit_stft_frame_ctrl.sv
// Frame controller in front of an external 4-point posit FFT datapath.
// Collects complex samples into a sliding 4-sample window, strobes the
// datapath with each full window, captures the spectrum and holds it on a
// valid/ready output. After each frame the window slides by HOP samples.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_valid/s_ready, s_re/s_im     sample input handshake and data
//   flush                          discard the partially filled frame
//   fft_valid_in, fft_x_re/im      frame strobe and data to the datapath
//   fft_valid_out, fft_y_re/im     datapath result
//   m_valid/m_ready, m_re/m_im     registered spectrum output handshake
//   frame_cnt                      frames delivered, wraps at 16 bits
//                                  (present only with STFT_FRAME_CNT_EN)
// The datapath is purely external; this block does no arithmetic on data.
module posit_stft_frame_ctrl
    import posit_stft_pkg::*;
#(
    parameter int DW  = DEFAULT_DW,
    parameter int HOP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_re,
    input  logic [DW-1:0]     s_im,
    input  logic              flush,
    output logic              fft_valid_in,
    output logic [4*DW-1:0]   fft_x_re,
    output logic [4*DW-1:0]   fft_x_im,
    input  logic              fft_valid_out,
    input  logic [4*DW-1:0]   fft_y_re,
    input  logic [4*DW-1:0]   fft_y_im,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [4*DW-1:0]   m_re,
    output logic [4*DW-1:0]   m_im
`ifdef STFT_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    // Legal hops are 1..NPT; anything outside is clamped into range.
    localparam int         HOP_C  = (HOP < 1) ? 1 : ((HOP > NPT) ? NPT : HOP);
    localparam logic [1:0] REFILL = refill_cnt(HOP_C);

    stft_state_t state;
    stft_state_t state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;
    logic        buf_wr;
    logic        buf_shift;
    logic        capture;

    posit_stft_frame_buf #(
        .DW  (DW),
        .HOP (HOP_C)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (buf_wr),
        .wr_idx   (cnt),
        .wr_re    (s_re),
        .wr_im    (s_im),
        .shift_en (buf_shift),
        .x_re     (fft_x_re),
        .x_im     (fft_x_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        s_ready      = 1'b0;
        fft_valid_in = 1'b0;
        m_valid      = 1'b0;
        buf_wr       = 1'b0;
        buf_shift    = 1'b0;
        capture      = 1'b0;
        case (state)
            ST_FILL: begin
                // flush wins over a simultaneous sample: nothing is taken
                s_ready = !flush;
                if (flush) begin
                    cnt_next = 2'd0;
                end else if (s_valid) begin
                    buf_wr   = 1'b1;
                    cnt_next = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                fft_valid_in = 1'b1;
                if (fft_valid_out) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    buf_shift  = 1'b1;
                    cnt_next   = REFILL;
                    state_next = ST_FILL;
                end
            end
            default: begin
                state_next = ST_FILL;
                cnt_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_re <= '0;
            m_im <= '0;
        end else if (capture) begin
            m_re <= fft_y_re;
            m_im <= fft_y_im;
        end
    end

`ifdef STFT_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'h0000;
        end else if (m_valid && m_ready) begin
            frame_cnt <= frame_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_posit_stft_frame_ctrl.sv
// Bench for posit_stft_frame_ctrl: two instances (HOP=2 and HOP=4) share
// clock, reset, flush and m_ready; each has its own sample source and a
// stub datapath with programmable latency.
module tb_posit_stft_frame_ctrl;

    localparam int DW = 32;
    localparam int FW = 4 * DW;
    localparam int ND = 2;
    localparam logic [DW-1:0] ONE = 32'h4000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    logic m_ready;
    int   dp_delay;

    logic          s_valid_w [ND];
    logic [DW-1:0] s_re_w    [ND];
    logic [DW-1:0] s_im_w    [ND];
    wire           s_ready_w       [ND];
    wire           fft_valid_in_w  [ND];
    wire           fft_valid_out_w [ND];
    wire           m_valid_w       [ND];
    wire [FW-1:0]  fft_x_re_w [ND];
    wire [FW-1:0]  fft_x_im_w [ND];
    wire [FW-1:0]  fft_y_re_w [ND];
    wire [FW-1:0]  fft_y_im_w [ND];
    wire [FW-1:0]  m_re_w     [ND];
    wire [FW-1:0]  m_im_w     [ND];
`ifdef STFT_FRAME_CNT_EN
    wire [15:0]    frame_cnt_w [ND];
`endif

    int tests = 0;
    int fails = 0;

    function automatic int hop_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    // slice i = x_i, x0 in the low slice
    function automatic logic [FW-1:0] pack4(input logic [DW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Stub datapath: exact spectrum for the all-ones frame, otherwise a
    // recognisable mapping so slice ordering errors show up.
    function automatic logic [FW-1:0] dp_re(input logic [FW-1:0] xr, input logic [FW-1:0] xi);
        logic [FW-1:0] y;
        y = '0;
        if (xr == {4{ONE}} && xi == '0) begin
            y = pack4(32'h5000_0000, 32'h0, 32'h0, 32'h0);
        end else begin
            for (int k = 0; k < 4; k++) y[k*DW +: DW] = xr[(3-k)*DW +: DW] + 32'(k + 1);
        end
        return y;
    endfunction

    function automatic logic [FW-1:0] dp_im(input logic [FW-1:0] xr, input logic [FW-1:0] xi);
        logic [FW-1:0] y;
        y = '0;
        if (!(xr == {4{ONE}} && xi == '0)) y = xr ^ xi;
        return y;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        int dp_age;

        posit_stft_frame_ctrl #(
            .DW  (DW),
            .HOP ((gi == 0) ? 2 : 4)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .s_valid       (s_valid_w[gi]),
            .s_ready       (s_ready_w[gi]),
            .s_re          (s_re_w[gi]),
            .s_im          (s_im_w[gi]),
            .flush         (flush),
            .fft_valid_in  (fft_valid_in_w[gi]),
            .fft_x_re      (fft_x_re_w[gi]),
            .fft_x_im      (fft_x_im_w[gi]),
            .fft_valid_out (fft_valid_out_w[gi]),
            .fft_y_re      (fft_y_re_w[gi]),
            .fft_y_im      (fft_y_im_w[gi]),
            .m_valid       (m_valid_w[gi]),
            .m_ready       (m_ready),
            .m_re          (m_re_w[gi]),
            .m_im          (m_im_w[gi])
`ifdef STFT_FRAME_CNT_EN
            ,
            .frame_cnt     (frame_cnt_w[gi])
`endif
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) dp_age <= 0;
            else if (fft_valid_in_w[gi] && !fft_valid_out_w[gi]) dp_age <= dp_age + 1;
            else dp_age <= 0;
        end
        assign fft_valid_out_w[gi] = fft_valid_in_w[gi] && (dp_age >= dp_delay);
        assign fft_y_re_w[gi]      = dp_re(fft_x_re_w[gi], fft_x_im_w[gi]);
        assign fft_y_im_w[gi]      = dp_im(fft_x_re_w[gi], fft_x_im_w[gi]);
    end

    // ---------------- reference model: sliding window of accepted samples
    logic [DW-1:0] w_re [ND][4];
    logic [DW-1:0] w_im [ND][4];
    int            w_n  [ND];
    logic          cap  [ND];
    logic [FW-1:0] cap_re [ND];
    logic [FW-1:0] cap_im [ND];
    int            age  [ND];
    int            mdl_frames [ND];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                w_n[d] <= 0; cap[d] <= 1'b0; age[d] <= 0; mdl_frames[d] <= 0;
                cap_re[d] <= '0; cap_im[d] <= '0;
                for (int i = 0; i < 4; i++) begin w_re[d][i] <= '0; w_im[d][i] <= '0; end
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (cap[d]) begin
                    if (m_ready) begin
                        for (int i = 0; i < 4 - hop_of(d); i++) begin
                            w_re[d][i] <= w_re[d][i + hop_of(d)];
                            w_im[d][i] <= w_im[d][i + hop_of(d)];
                        end
                        w_n[d]        <= 4 - hop_of(d);
                        cap[d]        <= 1'b0;
                        mdl_frames[d] <= mdl_frames[d] + 1;
                    end
                end else if (w_n[d] == 4) begin
                    if (age[d] >= dp_delay) begin
                        cap[d]    <= 1'b1;
                        cap_re[d] <= dp_re(pack4(w_re[d][0], w_re[d][1], w_re[d][2], w_re[d][3]),
                                           pack4(w_im[d][0], w_im[d][1], w_im[d][2], w_im[d][3]));
                        cap_im[d] <= dp_im(pack4(w_re[d][0], w_re[d][1], w_re[d][2], w_re[d][3]),
                                           pack4(w_im[d][0], w_im[d][1], w_im[d][2], w_im[d][3]));
                    end else begin
                        age[d] <= age[d] + 1;
                    end
                end else begin
                    age[d] <= 0;
                    if (flush) begin
                        w_n[d] <= 0;
                    end else if (s_valid_w[d]) begin
                        w_re[d][w_n[d]] <= s_re_w[d];
                        w_im[d][w_n[d]] <= s_im_w[d];
                        w_n[d]          <= w_n[d] + 1;
                    end
                end
            end
        end
    end

    // ---------------- compare process plus observation logs
    logic [FW-1:0] log_x   [ND][8];
    int            log_len [ND][8];
    int            log_n   [ND];
    logic [FW-1:0] log_m   [ND][8];
    int            dut_frames [ND];
    int            vin_run [ND];
    int            acc_n   [ND];
    int            acc4_cyc [ND];
    int            rise_cyc [ND];
    logic          mv_prev [ND];
    int            cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                chk($sformatf("rst_m_valid[%0d]", d), FW'(m_valid_w[d]), '0);
                chk($sformatf("rst_fft_valid_in[%0d]", d), FW'(fft_valid_in_w[d]), '0);
                log_n[d] <= 0; dut_frames[d] <= 0; vin_run[d] <= 0; acc_n[d] <= 0;
                acc4_cyc[d] <= -1; rise_cyc[d] <= -1; mv_prev[d] <= 1'b0;
            end else begin
                chk($sformatf("s_ready[%0d]", d), FW'(s_ready_w[d]),
                    FW'((w_n[d] < 4) && !flush && !cap[d]));
                chk($sformatf("fft_valid_in[%0d]", d), FW'(fft_valid_in_w[d]),
                    FW'((w_n[d] == 4) && !cap[d]));
                chk($sformatf("m_valid[%0d]", d), FW'(m_valid_w[d]), FW'(cap[d]));
                if (w_n[d] == 4 && !cap[d]) begin
                    chk($sformatf("fft_x_re[%0d]", d), fft_x_re_w[d],
                        pack4(w_re[d][0], w_re[d][1], w_re[d][2], w_re[d][3]));
                    chk($sformatf("fft_x_im[%0d]", d), fft_x_im_w[d],
                        pack4(w_im[d][0], w_im[d][1], w_im[d][2], w_im[d][3]));
                end
                if (cap[d]) begin
                    chk($sformatf("m_re[%0d]", d), m_re_w[d], cap_re[d]);
                    chk($sformatf("m_im[%0d]", d), m_im_w[d], cap_im[d]);
                end
`ifdef STFT_FRAME_CNT_EN
                chk($sformatf("frame_cnt[%0d]", d), FW'(frame_cnt_w[d]), FW'(16'(mdl_frames[d])));
`endif
                if (fft_valid_in_w[d] && fft_valid_out_w[d]) begin
                    if (log_n[d] < 8) begin
                        log_x[d][log_n[d]]   <= fft_x_re_w[d];
                        log_len[d][log_n[d]] <= vin_run[d] + 1;
                    end
                    log_n[d]   <= log_n[d] + 1;
                    vin_run[d] <= 0;
                end else if (fft_valid_in_w[d]) begin
                    vin_run[d] <= vin_run[d] + 1;
                end else begin
                    vin_run[d] <= 0;
                end
                if (m_valid_w[d] && m_ready) begin
                    if (dut_frames[d] < 8) log_m[d][dut_frames[d]] <= m_re_w[d];
                    dut_frames[d] <= dut_frames[d] + 1;
                end
                if (s_valid_w[d] && s_ready_w[d]) begin
                    if (acc_n[d] == 3) acc4_cyc[d] <= cyc;
                    acc_n[d] <= acc_n[d] + 1;
                end
                if (m_valid_w[d] && !mv_prev[d] && rise_cyc[d] < 0) rise_cyc[d] <= cyc;
                mv_prev[d] <= m_valid_w[d];
            end
        end
    end

    // ---------------- sample sources and sequencing
    logic [DW-1:0] src_re [ND][16];
    logic [DW-1:0] src_im [ND][16];
    int            src_len [ND];
    int            src_idx [ND];
    logic          acc [ND];

    task automatic load_val(input int d, input logic [DW-1:0] re, input logic [DW-1:0] im);
        if (src_len[d] < 16) begin
            src_re[d][src_len[d]] = re;
            src_im[d][src_len[d]] = im;
            src_len[d]++;
        end
    endtask

    task automatic load_seq(input int first, input int n);
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < n; k++) load_val(d, 32'(first + k), 32'(32'h100 + first + k));
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < ND; d++) acc[d] = s_valid_w[d] && s_ready_w[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            if (acc[d]) src_idx[d]++;
            if (src_idx[d] < src_len[d]) begin
                s_valid_w[d] = 1'b1;
                s_re_w[d]    = src_re[d][src_idx[d]];
                s_im_w[d]    = src_im[d][src_idx[d]];
            end else begin
                s_valid_w[d] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_src();
        for (int d = 0; d < ND; d++) begin
            src_len[d] = 0; src_idx[d] = 0; s_valid_w[d] = 1'b0;
            s_re_w[d] = '0; s_im_w[d] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        run(2);
        rst_n = 1'b1;
        run(1);
    endtask

    task automatic wait_mvalid(input int limit);
        int n;
        n = 0;
        while (!(m_valid_w[0] && m_valid_w[1]) && n < limit) begin
            step();
            n++;
        end
        tests++;
        if (!(m_valid_w[0] && m_valid_w[1])) begin
            fails++;
            $display("FAIL wait_m_valid: got timeout after %0d cycles required both m_valid high", limit);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1; dp_delay = 0;
        clear_src();

        // reset state
        do_reset();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_s_ready[%0d]", d), FW'(s_ready_w[d]), FW'(1));
            chk($sformatf("reset_m_valid[%0d]", d), FW'(m_valid_w[d]), '0);
            chk($sformatf("reset_fft_valid_in[%0d]", d), FW'(fft_valid_in_w[d]), '0);
            chk($sformatf("reset_m_re[%0d]", d), m_re_w[d], '0);
            chk($sformatf("reset_m_im[%0d]", d), m_im_w[d], '0);
            chk($sformatf("reset_fft_x_re[%0d]", d), fft_x_re_w[d], '0);
        end

        // four posit ones through the real-valued DC case
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < 4; k++) load_val(d, ONE, 32'h0);
        run(10);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("dc_frames[%0d]", d), FW'(dut_frames[d]), FW'(1));
            chk($sformatf("dc_m_re[%0d]", d), log_m[d][0], pack4(32'h5000_0000, 32'h0, 32'h0, 32'h0));
            chk($sformatf("dc_latency[%0d]", d), FW'(rise_cyc[d] - acc4_cyc[d]), FW'(2));
        end

        // samples 1..8: overlapping windows for HOP=2, disjoint for HOP=4
        do_reset();
        load_seq(1, 8);
        run(30);
        chk("hop2_frames", FW'(log_n[0]), FW'(3));
        chk("hop2_frame0", log_x[0][0], pack4(1, 2, 3, 4));
        chk("hop2_frame1", log_x[0][1], pack4(3, 4, 5, 6));
        chk("hop2_frame2", log_x[0][2], pack4(5, 6, 7, 8));
        chk("hop2_m1", log_m[0][1], pack4(7, 7, 7, 7));
        chk("hop2_out", FW'(dut_frames[0]), FW'(3));
        chk("hop4_frames", FW'(log_n[1]), FW'(2));
        chk("hop4_frame0", log_x[1][0], pack4(1, 2, 3, 4));
        chk("hop4_frame1", log_x[1][1], pack4(5, 6, 7, 8));

        // consumer stalls for 10 cycles in HOLD
        do_reset();
        m_ready = 1'b0;
        load_seq(11, 4);
        wait_mvalid(20);
        for (int c = 0; c < 10; c++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("stall_s_ready[%0d]", d), FW'(s_ready_w[d]), '0);
                chk($sformatf("stall_m_valid[%0d]", d), FW'(m_valid_w[d]), FW'(1));
                chk($sformatf("stall_m_re[%0d]", d), m_re_w[d], pack4(15, 15, 15, 15));
            end
        end
        m_ready = 1'b1;
        run(8);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("stall_frames[%0d]", d), FW'(dut_frames[d]), FW'(1));
            chk($sformatf("stall_m_valid_after[%0d]", d), FW'(m_valid_w[d]), '0);
        end

        // datapath answers three cycles late
        do_reset();
        dp_delay = 3;
        load_seq(41, 4);
        run(16);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("slow_captures[%0d]", d), FW'(log_n[d]), FW'(1));
            chk($sformatf("slow_vin_len[%0d]", d), FW'(log_len[d][0]), FW'(4));
            chk($sformatf("slow_frames[%0d]", d), FW'(dut_frames[d]), FW'(1));
        end
        dp_delay = 0;

        // flush with two samples buffered and a sample on offer
        do_reset();
        load_seq(21, 2);
        run(4);
        load_seq(23, 4);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        run(12);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("flush_captures[%0d]", d), FW'(log_n[d]), FW'(1));
            chk($sformatf("flush_frame[%0d]", d), log_x[d][0], pack4(23, 24, 25, 26));
        end

        // reset pulse while a result is held
        m_ready = 1'b0;
        load_seq(31, 4);
        wait_mvalid(20);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("async_m_valid[%0d]", d), FW'(m_valid_w[d]), '0);
        clear_src();
        run(2);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        run(10);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("post_rst_frames[%0d]", d), FW'(dut_frames[d]), '0);
            chk($sformatf("post_rst_m_re[%0d]", d), m_re_w[d], '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/posit_stft_frame_ctrl.md
POSIT_STFT_FRAME_CTRL -- requirements
Module: posit_stft_frame_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, posit word width per real/imag component.
REQ-002 SHALL have parameter HOP, default 2, frame hop in samples; legal range 1..4.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_valid  input  1  sample offered.
REQ-006 SHALL have port s_ready  output  1  sample accepted when s_valid&&s_ready.
REQ-007 SHALL have ports s_re, s_im  input  DW each  complex sample, posit encoded.
REQ-008 SHALL have port flush  input  1  discard partial frame.
REQ-009 SHALL have port fft_valid_in  output  1  frame strobe to 4-point posit FFT datapath.
REQ-010 SHALL have ports fft_x_re, fft_x_im  output  4*DW each  frame to datapath, slice i = x_i, x0 oldest.
REQ-011 SHALL have port fft_valid_out  input  1  datapath result valid.
REQ-012 SHALL have ports fft_y_re, fft_y_im  input  4*DW each  datapath result, slice k = X_k.
REQ-013 SHALL have port m_valid  output  1  spectrum frame available.
REQ-014 SHALL have port m_ready  input  1  consumer accepts when m_valid&&m_ready.
REQ-015 SHALL have ports m_re, m_im  output  4*DW each  registered spectrum, slice k = X_k.

Function
REQ-016 SHALL implement FSM states FILL, ISSUE, HOLD.
REQ-017 FILL: s_ready=1 unless flush=1; accepted sample written to buffer slot cnt, cnt increments; on acceptance with cnt==3 go ISSUE.
REQ-018 ISSUE: fft_valid_in=1 and fft_x_* driven from buffer; held until fft_valid_out=1; that cycle fft_y_* captured into m_re/m_im, go HOLD.
REQ-019 fft_x_* SHALL reflect buffer contents at all times; fft_valid_in=0 outside ISSUE.
REQ-020 HOLD: m_valid=1, m_re/m_im stable; on m_ready=1 shift buffer x[i]<=x[i+HOP] (i+HOP<4), set cnt=4-HOP, go FILL (HOP=4: cnt=0).
REQ-021 Latency with combinational datapath: 4th sample accepted edge N -> capture edge N+1 -> m_valid high from N+1 to handshake; throughput one frame per max(HOP,1)+2 cycles.
REQ-022 s_ready SHALL be 0 in ISSUE and HOLD (backpressure from m_ready propagates to source).
REQ-023 flush in FILL: cnt<=0, sample not accepted that cycle; flush in ISSUE/HOLD ignored.
REQ-024 m_valid SHALL drop the cycle after the m handshake; no duplicate frames emitted.
REQ-025 Buffer slots at index >= cnt SHALL be don't-care but deterministic (reset value 0).

Reset
REQ-026 On rst_n=0: state FILL, cnt=0, buffer=0, m_re/m_im=0, m_valid=0, fft_valid_in=0, s_ready=1 after release.
REQ-027 Reset mid-frame SHALL discard buffered samples and any held result without emitting.

Configuration
REQ-028 With STFT_FRAME_CNT_EN defined: output frame_cnt [15:0], reset 0, increments on each m handshake, wraps 0xFFFF->0x0000.
REQ-029 Without STFT_FRAME_CNT_EN: frame_cnt port and counter absent; all other behaviour identical.

Structure
REQ-030 Package posit_stft_pkg SHALL hold NPT=4, default DW, state enum type, posit constants (ONE=0x40000000, ZERO=0x00000000).
REQ-031 Sub-module posit_stft_frame_buf SHALL hold the 4-slot buffer, write-at-cnt and shift-by-HOP logic; FSM stays in the top.
REQ-032 Datapath SHALL remain external; controller contains no arithmetic.

Verification
REQ-033 HOP=4, four samples re=0x40000000 im=0, real datapath -> one frame, m_re X0=0x50000000, X1..X3=0, m_valid one cycle after 4th accept.
REQ-034 HOP=2, samples 1..8 distinct -> frames {1,2,3,4},{3,4,5,6},{5,6,7,8} on fft_x_re in order, 3 outputs.
REQ-035 m_ready held 0 for 10 cycles in HOLD -> s_ready=0, m_re stable all 10 cycles, single frame on release.
REQ-036 Stub datapath delaying fft_valid_out by 3 cycles -> fft_valid_in high 4 cycles, capture on 4th.
REQ-037 flush with cnt=2 and simultaneous s_valid -> sample dropped, next 4 accepted samples form the frame; rst_n pulse in HOLD -> m_valid=0 immediately, no output.
REQ-038 STFT_FRAME_CNT_EN, preload-free run of 65536 frames -> frame_cnt returns to 0x0000.
